// File: rtl/dp_arbiter_if.sv
// dp_arbiter_if
//   Bundles the two command masters (A = sample controller, B = coefficient
//   loader), the error clear/overflow handshake and the registered datapath
//   command bus into one interface.
//   modport slave  : the arbiter side (takes requests, drives grants/dp bus)
//   modport master : the requester/datapath side (drives requests, observes)
//   Signals: {a,b}_req, {a,b}_lock, {a,b}_op[2:0], {a,b}_src1/src2/dest[3:0],
//            {a,b}_gnt, {a,b}_err_clr, overflow, dp_op[2:0],
//            dp_src1/src2/dest[3:0], {a,b}_err, busy
interface dp_arbiter_if;
    logic       a_req;
    logic       a_lock;
    logic [2:0] a_op;
    logic [3:0] a_src1;
    logic [3:0] a_src2;
    logic [3:0] a_dest;
    logic       a_gnt;
    logic       b_req;
    logic       b_lock;
    logic [2:0] b_op;
    logic [3:0] b_src1;
    logic [3:0] b_src2;
    logic [3:0] b_dest;
    logic       b_gnt;
    logic       a_err_clr;
    logic       b_err_clr;
    logic       overflow;
    logic [2:0] dp_op;
    logic [3:0] dp_src1;
    logic [3:0] dp_src2;
    logic [3:0] dp_dest;
    logic       a_err;
    logic       b_err;
    logic       busy;

    modport slave (
        input  a_req, a_lock, a_op, a_src1, a_src2, a_dest,
        input  b_req, b_lock, b_op, b_src1, b_src2, b_dest,
        input  a_err_clr, b_err_clr, overflow,
        output a_gnt, b_gnt,
        output dp_op, dp_src1, dp_src2, dp_dest,
        output a_err, b_err, busy
    );

    modport master (
        output a_req, a_lock, a_op, a_src1, a_src2, a_dest,
        output b_req, b_lock, b_op, b_src1, b_src2, b_dest,
        output a_err_clr, b_err_clr, overflow,
        input  a_gnt, b_gnt,
        input  dp_op, dp_src1, dp_src2, dp_dest,
        input  a_err, b_err, busy
    );
endinterface

// File: rtl/dp_arbiter.sv
// dp_arbiter
//   Shares the FIR datapath command bus between master A (sample controller)
//   and master B (coefficient loader). One command is granted per cycle and
//   registered onto dp_*; grants are held off while a MUL occupies the
//   datapath, a master may lock ownership across a multi-op sequence, and
//   datapath overflow is attributed (sticky) to the master whose op caused it.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active-high
//   bus    : dp_arbiter_if.slave (requests, grants, dp_* command, errors, busy)
// Parameters
//   MUL_LAT      : cycles a MUL occupies the datapath (>=1)
//   LOCK_TIMEOUT : idle cycles of a locked owner before the lock is dropped
// Configuration
//   DP_ARB_ILLEGAL_CHK_EN : when defined, a granted op 7 is issued as NOP/0
//                           and flags the requester's err; when undefined,
//                           op 7 passes through untouched.
module dp_arbiter #(
    parameter int MUL_LAT      = 2,
    parameter int LOCK_TIMEOUT = 8
) (
    input logic         clk,
    input logic         reset,
    dp_arbiter_if.slave bus
);

    localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [MW-1:0] MUL_LOAD   = MW'(MUL_LAT - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]    OP_NOP     = 3'd0;
    localparam logic [2:0]    OP_MUL     = 3'd6;

    typedef enum logic [1:0] {ST_FREE, ST_LOCK_A, ST_LOCK_B} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] mul_cnt_q, mul_cnt_d;
    logic [TW-1:0] lock_cnt_q, lock_cnt_d;
    logic          last_b_q, last_b_d;
    logic [2:0]    dp_op_q, dp_op_d;
    logic [3:0]    dp_src1_q, dp_src1_d;
    logic [3:0]    dp_src2_q, dp_src2_d;
    logic [3:0]    dp_dest_q, dp_dest_d;
    logic          owner_b_q, owner_b_d;
    logic [2:0]    prev_op_q, prev_op_d;
    logic          prev_owner_b_q, prev_owner_b_d;
    logic          a_err_q, a_err_d;
    logic          b_err_q, b_err_d;

    logic          stall;
    logic          gnt_a, gnt_b, granted;
    logic          sel_lock;
    logic [2:0]    sel_op;
    logic          owner_gnt, owner_lock;
    logic          ill_a, ill_b;
    logic          ovf_set;

    // Grant selection, command mux and next-state. Overflow is judged against
    // the op that sat on dp_* in the previous cycle, so both that op and its
    // owner are carried one extra stage (prev_*).
    always_comb begin
        stall      = (mul_cnt_q != '0);
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        if (!stall && !reset) begin
            case (state_q)
                ST_FREE: begin
                    if (bus.a_req && bus.b_req) begin
                        gnt_a = last_b_q;
                        gnt_b = !last_b_q;
                    end else begin
                        gnt_a = bus.a_req;
                        gnt_b = bus.b_req;
                    end
                end
                ST_LOCK_A: gnt_a = bus.a_req;
                ST_LOCK_B: gnt_b = bus.b_req;
                default: begin
                    gnt_a = 1'b0;
                    gnt_b = 1'b0;
                end
            endcase
        end
        granted  = gnt_a | gnt_b;
        sel_op   = gnt_b ? bus.b_op   : bus.a_op;
        sel_lock = gnt_b ? bus.b_lock : bus.a_lock;

        dp_op_d   = OP_NOP;
        dp_src1_d = '0;
        dp_src2_d = '0;
        dp_dest_d = '0;
        if (granted) begin
            dp_op_d   = sel_op;
            dp_src1_d = gnt_b ? bus.b_src1 : bus.a_src1;
            dp_src2_d = gnt_b ? bus.b_src2 : bus.a_src2;
            dp_dest_d = gnt_b ? bus.b_dest : bus.a_dest;
        end
`ifdef DP_ARB_ILLEGAL_CHK_EN
        ill_a = gnt_a && (sel_op == 3'd7);
        ill_b = gnt_b && (sel_op == 3'd7);
        if (ill_a || ill_b) begin
            dp_op_d   = OP_NOP;
            dp_src1_d = '0;
            dp_src2_d = '0;
            dp_dest_d = '0;
        end
`else
        ill_a = 1'b0;
        ill_b = 1'b0;
`endif
        owner_b_d      = gnt_b;
        prev_op_d      = dp_op_q;
        prev_owner_b_d = owner_b_q;

        ovf_set = bus.overflow && (prev_op_q != OP_NOP);
        a_err_d = (a_err_q && !bus.a_err_clr) || (ovf_set && !prev_owner_b_q) || ill_a;
        b_err_d = (b_err_q && !bus.b_err_clr) || (ovf_set &&  prev_owner_b_q) || ill_b;

        if (granted && sel_op == OP_MUL)
            mul_cnt_d = MUL_LOAD;
        else if (stall)
            mul_cnt_d = mul_cnt_q - 1'b1;
        else
            mul_cnt_d = mul_cnt_q;

        last_b_d = granted ? gnt_b : last_b_q;

        // Lock bookkeeping only advances outside a MUL wait, which freezes
        // both the lock state and the timeout counter.
        owner_gnt  = (state_q == ST_LOCK_A) ? gnt_a : gnt_b;
        owner_lock = (state_q == ST_LOCK_A) ? bus.a_lock : bus.b_lock;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (!stall && !reset) begin
            if (state_q == ST_FREE) begin
                if (granted && sel_lock) begin
                    state_d    = gnt_a ? ST_LOCK_A : ST_LOCK_B;
                    lock_cnt_d = '0;
                end
            end else if (owner_gnt) begin
                lock_cnt_d = '0;
                if (!owner_lock)
                    state_d = ST_FREE;
            end else if (lock_cnt_q == LOCK_LAST) begin
                state_d    = ST_FREE;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    // All state registers; reset leaves the bus idle and gives A the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_FREE;
            mul_cnt_q      <= '0;
            lock_cnt_q     <= '0;
            last_b_q       <= 1'b1;
            dp_op_q        <= OP_NOP;
            dp_src1_q      <= '0;
            dp_src2_q      <= '0;
            dp_dest_q      <= '0;
            owner_b_q      <= 1'b0;
            prev_op_q      <= OP_NOP;
            prev_owner_b_q <= 1'b0;
            a_err_q        <= 1'b0;
            b_err_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            mul_cnt_q      <= mul_cnt_d;
            lock_cnt_q     <= lock_cnt_d;
            last_b_q       <= last_b_d;
            dp_op_q        <= dp_op_d;
            dp_src1_q      <= dp_src1_d;
            dp_src2_q      <= dp_src2_d;
            dp_dest_q      <= dp_dest_d;
            owner_b_q      <= owner_b_d;
            prev_op_q      <= prev_op_d;
            prev_owner_b_q <= prev_owner_b_d;
            a_err_q        <= a_err_d;
            b_err_q        <= b_err_d;
        end
    end

    assign bus.a_gnt   = gnt_a;
    assign bus.b_gnt   = gnt_b;
    assign bus.dp_op   = dp_op_q;
    assign bus.dp_src1 = dp_src1_q;
    assign bus.dp_src2 = dp_src2_q;
    assign bus.dp_dest = dp_dest_q;
    assign bus.a_err   = a_err_q;
    assign bus.b_err   = b_err_q;
    assign bus.busy    = (dp_op_q != OP_NOP) || stall || (state_q != ST_FREE);

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter
//   Directed bench for dp_arbiter (MUL_LAT=3, LOCK_TIMEOUT=8). Expected grants
//   and issued commands are queued as stimulus is applied; a monitor pops them
//   whenever a grant or a non-NOP dp_op appears. Also honours
//   DP_ARB_ILLEGAL_CHK_EN for the op-7 case.
module tb_dp_arbiter;

    localparam int MUL_LAT      = 3;
    localparam int LOCK_TIMEOUT = 8;

    typedef struct packed {
        logic       req;
        logic       lock;
        logic [2:0] op;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit          grant_q[$];
    logic [14:0] issue_q[$];

    always #5 clk = ~clk;

    dp_arbiter_if bus ();

    dp_arbiter #(.MUL_LAT(MUL_LAT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic cmd_t mk(input logic lock, input logic [2:0] op,
                                input logic [3:0] s1, input logic [3:0] s2,
                                input logic [3:0] d);
        cmd_t c;
        c.req = 1'b1; c.lock = lock; c.op = op; c.s1 = s1; c.s2 = s2; c.d = d;
        return c;
    endfunction

    function automatic logic [14:0] pl(input cmd_t c);
        return {c.op, c.s1, c.s2, c.d};
    endfunction

    task automatic checkOutput(input string name, input logic [14:0] actual,
                               input logic [14:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input cmd_t a, input cmd_t b);
        bus.a_req = a.req; bus.a_lock = a.lock; bus.a_op = a.op;
        bus.a_src1 = a.s1; bus.a_src2 = a.s2; bus.a_dest = a.d;
        bus.b_req = b.req; bus.b_lock = b.lock; bus.b_op = b.op;
        bus.b_src1 = b.s1; bus.b_src2 = b.s2; bus.b_dest = b.d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every grant and every non-NOP issue must match the
    // next queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.a_gnt || bus.b_gnt) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_grant: got a=%b b=%b expected none at %0t",
                             bus.a_gnt, bus.b_gnt, $time);
                end else begin
                    bit exp_b;
                    exp_b = grant_q.pop_front();
                    checkOutput("grant_a", 15'(bus.a_gnt), 15'(!exp_b));
                    checkOutput("grant_b", 15'(bus.b_gnt), 15'(exp_b));
                end
            end
            if (bus.dp_op != 3'd0) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_issue: got op=%0d expected none at %0t",
                             bus.dp_op, $time);
                end else begin
                    checkOutput("issue", {bus.dp_op, bus.dp_src1, bus.dp_src2, bus.dp_dest},
                                issue_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmd_t idle, a_add, b_sub, a_mul, b_add, a_ld2, b_cpy, a_ill, a_cp2, b_lk;
        idle  = '0;
        a_add = mk(1'b0, 3'd4, 4'd1, 4'd2, 4'd3);
        b_sub = mk(1'b0, 3'd5, 4'd4, 4'd5, 4'd6);
        a_mul = mk(1'b0, 3'd6, 4'd1, 4'd2, 4'd3);
        b_add = mk(1'b0, 3'd4, 4'd7, 4'd8, 4'd9);
        a_ld2 = mk(1'b1, 3'd3, 4'd0, 4'd0, 4'd7);
        b_cpy = mk(1'b0, 3'd1, 4'd2, 4'd0, 4'd5);
        a_ill = mk(1'b0, 3'd7, 4'd1, 4'd2, 4'd3);
        a_cp2 = mk(1'b0, 3'd2, 4'd3, 4'd0, 4'd9);
        b_lk  = mk(1'b1, 3'd1, 4'd4, 4'd0, 4'd8);

        // Reset with a request pending: nothing may be granted or issued.
        rst = 1'b1;
        bus.a_err_clr = 1'b0; bus.b_err_clr = 1'b0; bus.overflow = 1'b0;
        applyStimulus(a_add, idle);
        sample();
        checkOutput("rst_a_gnt", 15'(bus.a_gnt), 15'd0);
        checkOutput("rst_dp_op", 15'(bus.dp_op), 15'd0);
        checkOutput("rst_busy",  15'(bus.busy),  15'd0);
        checkOutput("rst_a_err", 15'(bus.a_err), 15'd0);
        checkOutput("rst_b_err", 15'(bus.b_err), 15'd0);
        tick();
        rst = 1'b0;
        applyStimulus(idle, idle);
        sample();
        checkOutput("idle_a_gnt", 15'(bus.a_gnt), 15'd0);
        checkOutput("idle_b_gnt", 15'(bus.b_gnt), 15'd0);
        checkOutput("idle_busy",  15'(bus.busy),  15'd0);

        // Round robin on a tie: A, B, A, B.
        tick();
        applyStimulus(a_add, b_sub);
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(i[0]);
            issue_q.push_back(i[0] ? pl(b_sub) : pl(a_add));
        end
        for (int i = 0; i < 4; i++) begin
            sample();
            tick();
        end
        applyStimulus(idle, idle);
        sample();
        checkOutput("rr_busy_last_issue", 15'(bus.busy), 15'd1);
        tick();
        sample();
        checkOutput("rr_dp_nop_after_idle", 15'(bus.dp_op), 15'd0);
        checkOutput("rr_busy_idle", 15'(bus.busy), 15'd0);

        // MUL wait: B held off for MUL_LAT-1 cycles, then granted.
        tick();
        applyStimulus(a_mul, b_add);
        grant_q.push_back(1'b0);
        issue_q.push_back(pl(a_mul));
        sample();
        tick();
        applyStimulus(idle, b_add);
        sample();
        checkOutput("mul_wait1_b_gnt", 15'(bus.b_gnt), 15'd0);
        tick();
        sample();
        checkOutput("mul_wait2_b_gnt", 15'(bus.b_gnt), 15'd0);
        checkOutput("mul_wait2_dp_op", 15'(bus.dp_op), 15'd0);
        checkOutput("mul_wait2_busy",  15'(bus.busy),  15'd1);
        tick();
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_add));
        sample();
        checkOutput("mul_after_b_gnt", 15'(bus.b_gnt), 15'd1);
        tick();
        applyStimulus(idle, idle);
        sample();
        tick();

        // Lock by A, then A idle: B waits out the LOCK_TIMEOUT window.
        applyStimulus(a_ld2, b_cpy);
        grant_q.push_back(1'b0);
        issue_q.push_back(pl(a_ld2));
        sample();
        for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
            tick();
            if (k == 1) applyStimulus(idle, b_cpy);
            sample();
            checkOutput("lock_hold_b_gnt", 15'(bus.b_gnt), 15'd0);
            if (k == 5) checkOutput("lock_hold_busy", 15'(bus.busy), 15'd1);
        end
        tick();
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_cpy));
        sample();
        checkOutput("lock_timeout_b_gnt", 15'(bus.b_gnt), 15'd1);
        tick();
        applyStimulus(idle, idle);
        sample();
        tick();

        // Overflow attributed to B; clear in the same cycle loses to set.
        applyStimulus(idle, b_add);
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_add));
        sample();
        tick();
        applyStimulus(idle, idle);
        sample();
        tick();
        bus.overflow = 1'b1;
        bus.b_err_clr = 1'b1;
        sample();
        tick();
        bus.overflow = 1'b0;
        sample();
        checkOutput("ovf_b_err_set", 15'(bus.b_err), 15'd1);
        checkOutput("ovf_a_err_clear", 15'(bus.a_err), 15'd0);
        tick();
        bus.b_err_clr = 1'b0;
        bus.overflow = 1'b1;
        sample();
        checkOutput("ovf_b_err_cleared", 15'(bus.b_err), 15'd0);
        tick();
        bus.overflow = 1'b0;
        sample();
        checkOutput("ovf_ignored_a_err", 15'(bus.a_err), 15'd0);
        checkOutput("ovf_ignored_b_err", 15'(bus.b_err), 15'd0);

        // Op 7 from A.
        tick();
        applyStimulus(a_ill, idle);
        grant_q.push_back(1'b0);
`ifndef DP_ARB_ILLEGAL_CHK_EN
        issue_q.push_back(pl(a_ill));
`endif
        sample();
        tick();
        applyStimulus(idle, idle);
        sample();
`ifdef DP_ARB_ILLEGAL_CHK_EN
        checkOutput("ill_dp_op", 15'(bus.dp_op), 15'd0);
        checkOutput("ill_a_err", 15'(bus.a_err), 15'd1);
`else
        checkOutput("ill_dp_op", 15'(bus.dp_op), 15'd7);
        checkOutput("ill_a_err", 15'(bus.a_err), 15'd0);
`endif
        tick();
        bus.a_err_clr = 1'b1;
        sample();
        tick();
        bus.a_err_clr = 1'b0;
        sample();
        checkOutput("ill_a_err_cleared", 15'(bus.a_err), 15'd0);

        // B locks (wins tie since A went last), keeps A out, releases with lock=0.
        tick();
        applyStimulus(a_cp2, b_lk);
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_lk));
        sample();
        tick();
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_lk));
        sample();
        checkOutput("lockb_a_gnt", 15'(bus.a_gnt), 15'd0);
        tick();
        b_lk.lock = 1'b0;
        applyStimulus(a_cp2, b_lk);
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_lk));
        sample();
        tick();
        applyStimulus(a_cp2, idle);
        grant_q.push_back(1'b0);
        issue_q.push_back(pl(a_cp2));
        sample();
        tick();
        applyStimulus(idle, idle);
        sample();
        tick();

        // Reset in the middle of a MUL wait clears the wait immediately.
        applyStimulus(a_mul, idle);
        grant_q.push_back(1'b0);
        issue_q.push_back(pl(a_mul));
        sample();
        tick();
        applyStimulus(idle, idle);
        sample();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_mul_dp_op", 15'(bus.dp_op), 15'd0);
        checkOutput("rst_mid_mul_busy",  15'(bus.busy),  15'd0);
        tick();
        rst = 1'b0;
        applyStimulus(idle, b_add);
        grant_q.push_back(1'b1);
        issue_q.push_back(pl(b_add));
        sample();
        checkOutput("post_rst_b_gnt", 15'(bus.b_gnt), 15'd1);
        tick();
        applyStimulus(idle, idle);
        sample();
        tick();
        sample();

        checkOutput("grant_queue_empty", 15'(grant_q.size()), 15'd0);
        checkOutput("issue_queue_empty", 15'(issue_q.size()), 15'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
